ddr_arbiter: RTL and testbench

- Shares the single DDR command engine among three requesters: video line-fetch reads, drawing-engine writes, and periodic auto-refresh.
- Sits between the VGA/drawing front ends and the DDR controller.
- Becomes active once the controller reports power-up initialisation complete.
- Issues one command at a time and tracks it to completion.

---
 rtl/ddr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the DDR command engine between video reads, drawing writes and auto-refresh.
// Optional completion counters are built when DDR_ARB_STATS_EN is defined; otherwise they read 0.
module ddr_arbiter #(
  parameter int ADDR_W           = 25,
  parameter int REFRESH_INTERVAL = 1000,
  parameter int MAX_RD_STREAK    = 4
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic              refresh_overrun,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       ref_count
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  localparam int              CNT_W      = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]       STREAK_MAX = 3'(MAX_RD_STREAK);

  state_t            state;
  logic [CNT_W-1:0]  ref_cnt;
  logic              refresh_pending;
  logic [2:0]        rd_streak;
  logic [1:0]        grant_op;
  logic              expire;
  logic              ref_clear;

  assign expire    = (state != S_INIT) && (ref_cnt == '0);
  assign ref_clear = (state == S_WAIT) && cmd_done && (cmd_op == OP_REF);

  // Source selection; reads and writes are not re-granted in an ack cycle
  always_comb begin
    grant_op = OP_NONE;
    if (refresh_pending) begin
      grant_op = OP_REF;
    end else if (rd_ack || wr_ack) begin
      grant_op = OP_NONE;
    end else if (wr_req && (rd_streak == STREAK_MAX)) begin
      grant_op = OP_WR;
    end else if (rd_req) begin
      grant_op = OP_RD;
    end else if (wr_req) begin
      grant_op = OP_WR;
    end else begin
      grant_op = OP_NONE;
    end
  end

  // Refresh interval timer, pending flag and sticky overrun
  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      ref_cnt         <= RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else if (state != S_INIT) begin
      if (expire) begin
        ref_cnt         <= RELOAD;
        refresh_pending <= 1'b1;
        if (refresh_pending && !ref_clear) begin
          refresh_overrun <= 1'b1;
        end
      end else begin
        ref_cnt <= ref_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        if (ref_clear) begin
          refresh_pending <= 1'b0;
        end
      end
    end
  end

  // Command FSM with registered command and ack outputs
  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NONE;
      cmd_addr  <= '0;
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
      rd_streak <= 3'd0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_done) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (grant_op != OP_NONE) begin
            cmd_op    <= grant_op;
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
            case (grant_op)
              OP_RD: begin
                cmd_addr <= rd_addr;
                if (!wr_req) begin
                  rd_streak <= 3'd0;
                end else if (rd_streak != 3'd7) begin
                  rd_streak <= rd_streak + 3'd1;
                end
              end
              OP_WR: begin
                cmd_addr  <= wr_addr;
                rd_streak <= 3'd0;
              end
              default: cmd_addr <= '0;
            endcase
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            rd_ack   <= (cmd_op == OP_RD);
            wr_ack   <= (cmd_op == OP_WR);
            cmd_op   <= OP_NONE;
            cmd_addr <= '0;
            state    <= S_IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= S_INIT;
        end
      endcase
    end
  end

`ifdef DDR_ARB_STATS_EN
  // Saturating completion counters
  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      ref_count <= 16'd0;
    end else begin
      if (rd_ack && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_ack && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (ref_clear && (ref_count != 16'hFFFF)) begin
        ref_count <= ref_count + 16'd1;
      end
    end
  end
`else
  assign rd_count  = 16'd0;
  assign wr_count  = 16'd0;
  assign ref_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed testbench for ddr_arbiter (REFRESH_INTERVAL=20, MAX_RD_STREAK=4).
module tb_ddr_arbiter;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_done = 1'b0;
  logic          rd_ack, wr_ack, cmd_valid, refresh_overrun;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   rd_count, wr_count, ref_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr_arbiter #(.ADDR_W(AW), .REFRESH_INTERVAL(20), .MAX_RD_STREAK(4)) dut (
    .clk133_p(clk), .rst(rst), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .refresh_overrun(refresh_overrun),
    .rd_count(rd_count), .wr_count(wr_count), .ref_count(ref_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_valid, cmd_op, cmd_addr, rd_ack, wr_ack, refresh_overrun} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {cmd_valid, cmd_op, cmd_addr, rd_ack, wr_ack, refresh_overrun});
    end
    total++;
    if ({rd_count, wr_count, ref_count} !== 48'd0) begin
      bad++; $display("FAIL reset_counts: got %h want 0", {rd_count, wr_count, ref_count});
    end
  endtask

  task automatic test_init_holdoff();
    int early = 0;
    int acks = 0;
    do_reset();
    rd_addr = 25'h0001234; rd_req = 1'b1; cmd_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cmd_valid !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL init_holdoff: got %0d valid cycles want 0", early); end
    init_done = 1'b1;
    tick();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL init_first_cycle: got valid=%b want 0", cmd_valid); end
    tick();
    total++;
    if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'b01, 25'h0001234}) begin
      bad++; $display("FAIL init_read_cmd: got v=%b op=%b a=%h want v=1 op=01 a=0001234", cmd_valid, cmd_op, cmd_addr);
    end
    tick();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL init_valid_drop: got %b want 0", cmd_valid); end
    repeat (4) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    total++;
    if (rd_ack !== 1'b1) begin bad++; $display("FAIL init_rd_ack: got %b want 1", rd_ack); end
    tick();
    rd_req = 1'b0;
    if (rd_ack === 1'b1) acks++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL init_ack_once: got %0d extra acks want 0", acks); end
    total++;
`ifdef DDR_ARB_STATS_EN
    if (rd_count !== 16'd1) begin bad++; $display("FAIL init_rd_count: got %0d want 1", rd_count); end
`else
    if (rd_count !== 16'd0) begin bad++; $display("FAIL init_rd_count: got %0d want 0", rd_count); end
`endif
  endtask

  task automatic test_refresh_cadence();
    int last = -1;
    int nref = 0;
    int cd = 0;
    do_reset();
    init_done = 1'b1; cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 230; cyc++) begin
      tick();
      if (cd != 0) cd--;
      if (cmd_valid === 1'b1) begin
        total++;
        if (cmd_op !== 2'b11 || cmd_addr !== '0) begin
          bad++; $display("FAIL cadence_cmd: got op=%b a=%h want op=11 a=0", cmd_op, cmd_addr);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != 20) begin bad++; $display("FAIL cadence_period: got %0d want 20", cyc - last); end
        end
        last = cyc; nref++; cd = 4;
      end
      cmd_done = (cd == 1);
    end
    cmd_done = 1'b0;
    total++;
    if (nref != 11) begin bad++; $display("FAIL cadence_count: got %0d want 11", nref); end
    total++;
    if (refresh_overrun !== 1'b0) begin bad++; $display("FAIL cadence_overrun: got %b want 0", refresh_overrun); end
    total++;
`ifdef DDR_ARB_STATS_EN
    if (ref_count !== 16'd11) begin bad++; $display("FAIL cadence_ref_count: got %0d want 11", ref_count); end
`else
    if (ref_count !== 16'd0) begin bad++; $display("FAIL cadence_ref_count: got %0d want 0", ref_count); end
`endif
  endtask

  task automatic test_overrun();
    do_reset();
    init_done = 1'b1; cmd_ready = 1'b0;
    repeat (30) tick();
    total++;
    if ({cmd_valid, cmd_op, refresh_overrun} !== {1'b1, 2'b11, 1'b0}) begin
      bad++; $display("FAIL overrun_first: got v=%b op=%b ovr=%b want v=1 op=11 ovr=0", cmd_valid, cmd_op, refresh_overrun);
    end
    repeat (15) tick();
    total++;
    if (refresh_overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", refresh_overrun); end
    cmd_ready = 1'b1;
    tick();
    repeat (2) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    repeat (3) tick();
    total++;
    if ({cmd_valid, refresh_overrun} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL overrun_sticky: got v=%b ovr=%b want v=0 ovr=1", cmd_valid, refresh_overrun);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] got = '0;
    logic       last_w = 1'b0;
    int n = 0, racks = 0, wacks = 0, wbad = 0;
    do_reset();
    init_done = 1'b1; cmd_ready = 1'b1; cmd_done = 1'b1;
    rd_addr = 25'h0000111; wr_addr = 25'h0000222;
    rd_req = 1'b1; wr_req = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      tick();
      if (rd_ack === 1'b1) racks++;
      if (wr_ack === 1'b1) begin
        wacks++;
        if (!last_w) wbad++;
        if (n == 10) wr_req = 1'b0;
      end
      if (cmd_valid === 1'b1 && cmd_op !== 2'b11 && n < 10) begin
        got[n] = (cmd_op === 2'b10);
        last_w = (cmd_op === 2'b10);
        n++;
        if (n == 10) rd_req = 1'b0;
      end
    end
    cmd_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    total++;
    if (n != 10) begin bad++; $display("FAIL starve_grants: got %0d want 10", n); end
    total++;
    if (got !== 10'b10_0001_0000) begin bad++; $display("FAIL starve_order: got %b want 1000010000 (bit0 first, 1=W)", got); end
    total++;
    if (racks != 8 || wacks != 2) begin bad++; $display("FAIL starve_acks: got rd=%0d wr=%0d want rd=8 wr=2", racks, wacks); end
    total++;
    if (wbad != 0) begin bad++; $display("FAIL starve_wr_ack_follow: got %0d stray wr_acks want 0", wbad); end
  endtask

  task automatic test_refresh_priority();
    do_reset();
    init_done = 1'b1; cmd_ready = 1'b1; rd_addr = 25'h1ABCDEF;
    repeat (21) tick();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL prio_quiet: got %b want 0", cmd_valid); end
    rd_req = 1'b1;
    tick();
    total++;
    if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'b11, 25'h0}) begin
      bad++; $display("FAIL prio_refresh_first: got v=%b op=%b a=%h want v=1 op=11 a=0", cmd_valid, cmd_op, cmd_addr);
    end
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    total++;
    if ({cmd_valid, rd_ack} !== 2'b00) begin bad++; $display("FAIL prio_refresh_done: got v=%b ack=%b want 00", cmd_valid, rd_ack); end
    tick();
    total++;
    if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'b01, 25'h1ABCDEF}) begin
      bad++; $display("FAIL prio_read_next: got v=%b op=%b a=%h want v=1 op=01 a=1abcdef", cmd_valid, cmd_op, cmd_addr);
    end
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    total++;
    if (rd_ack !== 1'b1) begin bad++; $display("FAIL prio_read_ack: got %b want 1", rd_ack); end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_command();
    int acks = 0;
    do_reset();
    init_done = 1'b1; wr_addr = 25'h0055AA5; wr_req = 1'b1; cmd_ready = 1'b0;
    repeat (2) tick();
    total++;
    if (cmd_valid !== 1'b1) begin bad++; $display("FAIL rstmid_issue: got %b want 1", cmd_valid); end
    rst = 1'b1;
    #1;
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid_drop: got %b want 0", cmd_valid); end
    rst = 1'b0;
    repeat (2) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_done = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_valid, wr_ack} !== 2'b00) begin bad++; $display("FAIL rstmid_wait: got v=%b ack=%b want 00", cmd_valid, wr_ack); end
    repeat (2) tick();
    rst = 1'b0; cmd_done = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    total++;
    if ({rd_count, wr_count, ref_count} !== 48'd0) begin
      bad++; $display("FAIL rstmid_counts: got %h want 0", {rd_count, wr_count, ref_count});
    end
  endtask

  initial begin
    test_reset();
    test_init_holdoff();
    test_refresh_cadence();
    test_overrun();
    test_starvation();
    test_refresh_priority();
    test_reset_mid_command();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
